// File: rtl/pc_target_table.sv
// pc_target_table: reloadable jump-target lookup table with a 1-cycle response.
// Optional feature macro: PC_TGT_RELATIVE_EN adds PC-relative lookups (Rel, CurPC).
module pc_target_table #(
    parameter int ADDR_W = 4,
    parameter int TGT_W  = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LoadStart,
    input  logic              LoadValid,
    input  logic [TGT_W-1:0]  LoadData,
    output logic              LoadReady,
    output logic              LoadDone,
    input  logic              ReqValid,
    input  logic [ADDR_W-1:0] Addr,
    output logic              RspValid,
    output logic [TGT_W-1:0]  Target,
    output logic              Hit
`ifdef PC_TGT_RELATIVE_EN
    ,
    input  logic              Rel,
    input  logic [TGT_W-1:0]  CurPC
`endif
);

    localparam int ENTRIES = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [ENTRIES-1:0]  valid;
    logic [TGT_W-1:0]    mem [ENTRIES];

    logic                wr_en;
    logic                last;
    logic [TGT_W-1:0]    base;
    logic [TGT_W-1:0]    rsp_tgt;

    assign wr_en = (state == LOAD) && LoadValid && !LoadStart && !Reset;
    assign last  = (ptr == ADDR_W'(ENTRIES - 1));
    assign base  = valid[Addr] ? mem[Addr] : TGT_W'(Addr);

`ifdef PC_TGT_RELATIVE_EN
    assign rsp_tgt = Rel ? (base + CurPC) : base;
`else
    assign rsp_tgt = base;
`endif

    // Load FSM: restart/clear on LoadStart, sequential fill, one-cycle done pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            ptr       <= '0;
            valid     <= '0;
            LoadReady <= 1'b0;
            LoadDone  <= 1'b0;
        end else begin
            LoadDone <= 1'b0;
            if (LoadStart) begin
                state     <= LOAD;
                ptr       <= '0;
                valid     <= '0;
                LoadReady <= 1'b1;
            end else begin
                unique case (state)
                    LOAD: begin
                        if (LoadValid) begin
                            valid[ptr] <= 1'b1;
                            if (last) begin
                                state     <= DONE;
                                LoadReady <= 1'b0;
                                LoadDone  <= 1'b1;
                            end else begin
                                ptr <= ptr + ADDR_W'(1);
                            end
                        end
                    end
                    DONE: state <= IDLE;
                    default: ;
                endcase
            end
        end
    end

    // Entry storage; validity comes only from the valid bits, so no reset
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[ptr] <= LoadData;
        end
    end

    // Lookup response: reads pre-write contents, holds while idle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            RspValid <= 1'b0;
            Target   <= '0;
            Hit      <= 1'b0;
        end else begin
            RspValid <= ReqValid;
            if (ReqValid) begin
                Target <= rsp_tgt;
                Hit    <= valid[Addr];
            end
        end
    end

endmodule

// File: doc/pc_target_table.md
PC_TARGET_TABLE -- requirements
Module: pc_target_table

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: lookup index width; table depth ENTRIES = 2**ADDR_W.
REQ-002 SHALL have parameter TGT_W, default 10: target width, in InstMem address bits.
REQ-003 SHALL have port Clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port LoadStart, input, 1: begin a table reload.
REQ-006 SHALL have port LoadValid, input, 1: LoadData is valid.
REQ-007 SHALL have port LoadData, input, TGT_W: next table entry, written in index order.
REQ-008 SHALL have port LoadReady, output, 1: table accepts LoadData this cycle.
REQ-009 SHALL have port LoadDone, output, 1: one-cycle pulse after the last entry is written.
REQ-010 SHALL have port ReqValid, input, 1: lookup request.
REQ-011 SHALL have port Addr, input, ADDR_W: lookup index.
REQ-012 SHALL have port RspValid, output, 1: Target and Hit are valid.
REQ-013 SHALL have port Target, output, TGT_W: absolute jump target.
REQ-014 SHALL have port Hit, output, 1: the indexed entry was loaded since the last clear.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD and DONE.
REQ-016 In IDLE, LoadStart=1 SHALL clear every entry valid bit, set the write pointer to 0 and move to LOAD.
REQ-017 LoadReady SHALL be 1 exactly while in LOAD and 0 otherwise.
REQ-018 In LOAD, LoadValid&LoadReady SHALL write LoadData to entry[ptr], set valid[ptr] and increment ptr.
REQ-019 When the entry at ptr = ENTRIES-1 is accepted, the FSM SHALL go to DONE; ptr SHALL NOT wrap within a load.
REQ-020 DONE SHALL last one cycle with LoadDone=1, then go to IDLE.
REQ-021 LoadStart=1 in LOAD or DONE SHALL restart the load: clear valid bits, ptr=0, state LOAD. LoadStart takes priority over a same-cycle LoadValid.
REQ-022 LoadValid outside LOAD SHALL be ignored.
REQ-023 Lookups SHALL be serviced in every state with a fixed latency of 1: RspValid(t+1) = ReqValid(t).
REQ-024 If valid[Addr]=1, the response SHALL be Target = entry[Addr], Hit=1.
REQ-025 If valid[Addr]=0, the response SHALL be Target = Addr zero-extended to TGT_W, Hit=0.
REQ-026 A lookup and a write to the same index in the same cycle SHALL return the pre-write value (read-before-write).
REQ-027 Target and Hit SHALL hold their last value while RspValid=0.

Reset
REQ-028 Reset=1 SHALL force: state IDLE, ptr 0, all valid bits 0, LoadReady 0, LoadDone 0, RspValid 0, Target 0, Hit 0.
REQ-029 Reset SHALL take priority over LoadStart, LoadValid and ReqValid in the same cycle.
REQ-030 Reset SHALL abort a load in progress, and no LoadDone pulse SHALL follow.
REQ-031 Entry data storage need not be reset; Hit and Target SHALL be correct from the valid bits alone.

Configuration
REQ-032 Macro PC_TGT_RELATIVE_EN defined: the block SHALL add inputs Rel (1 bit) and CurPC (TGT_W bits), sampled with ReqValid.
REQ-033 With PC_TGT_RELATIVE_EN and Rel=1, the block SHALL respond with Target = CurPC + (entry or default value from REQ-024/025), modulo 2**TGT_W, with wrap and no overflow flag. Hit SHALL follow the same rules as the absolute case.
REQ-034 Macro PC_TGT_RELATIVE_EN undefined: Rel and CurPC SHALL be absent, and all lookups SHALL be absolute per REQ-024/025.

Verification
REQ-035 Reset, then lookup Addr=3 -> one cycle later RspValid=1, Target=3, Hit=0.
REQ-036 LoadStart, then stream 15,15,7,19,... for 16 entries with LoadValid held high -> LoadReady high for 16 cycles, a single LoadDone pulse, then lookup Addr=3 -> Target=19, Hit=1.
REQ-037 Drop LoadValid mid-load after 5 entries, lookup Addr=4 and Addr=5 -> Addr=4 gives its loaded value with Hit=1; Addr=5 gives Target=5, Hit=0; load resumes at ptr 5.
REQ-038 LoadStart during LOAD at ptr 9 -> all Hit=0 next cycle, ptr restarts at 0, and LoadDone appears only after 16 further writes.
REQ-039 Lookup Addr=2 in the same cycle entry 2 is written with 100 -> response shows the old value; a repeat lookup gives 100.
REQ-040 With PC_TGT_RELATIVE_EN: entry[1]=1000, CurPC=100, Rel=1, TGT_W=10 -> Target=76 (wrap), Hit=1. Reset asserted mid-load -> no LoadDone, all outputs 0.
